frac_pi_master: RTL and testbench
=================================

// Module: frac_pi_master
// PURPOSE
//  uP-bus initiator that programs one fractal point job into the fractal unit register block and returns the result.
//  - Accepts a job (cx, cy, max_iter) on a valid/ready port.
//  - Issues byte writes for cx, cy and max_iter, then sets the go bit.
//  - Polls the control/status register until the unit is idle.
//  - Returns the found flag on a valid/ready result port.
//  - Replaces software polling for batch rendering; drives the same blk_sel/addr/wr_en/rd_en/wr_data/rd_data bus.
// PARAMETERS
//  A_CTRL      4'h0  control/status reg (wr bit0=go; rd bit0=busy, bit1=found)
//  A_CX0       4'h1  cx[7:0]; cx bytes at A_CX0..A_CX0+3, low byte first
//  A_CY0       4'h5  cy[7:0]; cy bytes at A_CY0..A_CY0+3
//  A_ITER0     4'h9  max_iter[7:0]; max_iter[15:8] at A_ITER0+1
//  POLL_GAP    4     idle cycles between status reads in POLL (0 = every cycle)
//  ARM_WAIT    16    max status reads waiting for busy to rise after go
//  TIMEOUT_CYC 65536 busy cycles before abort (only with FRAC_PI_MASTER_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  job_valid    in   1   job request
//  job_ready    out  1   high only in IDLE
//  job_cx       in   32  seed real part, latched on accept
//  job_cy       in   32  seed imag part, latched on accept
//  job_max_iter in   16  iteration limit, latched on accept
//  res_valid    out  1   result available; held until res_ready
//  res_ready    in   1   result consumer ready
//  res_found    out  1   status bit1 from final read
//  res_timeout  out  1   job aborted by timeout
//  blk_sel      out  1   bus select, high with every wr_en/rd_en
//  addr         out  4   register address
//  wr_en        out  1   one-cycle write strobe
//  rd_en        out  1   one-cycle read strobe
//  wr_data      out  8   write byte
//  rd_data      in   8   read data; combinational from slave, sampled in the rd_en cycle
// BEHAVIOUR
//  Reset and bus rules
//  - One clock. Reset is asynchronous and active-low.
//  - While rst_n=0: all outputs 0, FSM = IDLE, latched job cleared.
//  - job_ready rises on the first clk edge after rst_n release.
//  - Reset mid-job: strobes drop immediately. No partial access completes and nothing is resumed.
//  - All bus outputs are registered. At most one access per cycle; wr_en and rd_en are never high together.
//  - Between accesses blk_sel=0, addr=0, wr_data=0.
//  FSM: IDLE -> WR -> GO -> ARM -> POLL -> FINAL -> RESP -> IDLE
//  - IDLE: job_ready=1. On job_valid&&job_ready (cycle 0), latch the job; job_ready=0 next cycle.
//  - WR: cycles 1..10, one write per cycle:
//    - cx bytes 0..3 to A_CX0..+3
//    - cy bytes 0..3 to A_CY0..+3
//    - max_iter low byte to A_ITER0, high byte to A_ITER0+1
//  - GO: cycle 11 writes 8'h01 to A_CTRL.
//  - ARM: reads A_CTRL every cycle.
//    - rd_data[0]=1 -> POLL.
//    - ARM_WAIT reads without busy -> FINAL (job finished before first sample).
//  - POLL: reads A_CTRL, then POLL_GAP idle cycles, repeat.
//    - rd_data[0]=0 -> FINAL.
//  - FINAL: one extra A_CTRL read at least 1 cycle after idle was seen; captures res_found=rd_data[1].
//  - RESP: res_valid=1 with res_found/res_timeout stable.
//    - res_valid&&res_ready -> IDLE; res_valid=0 and job_ready=1 next cycle.
//  - No job is accepted while a result is pending. Back-to-back jobs are allowed after IDLE re-entry.
// CONFIGURATION
//  FRAC_PI_MASTER_TIMEOUT_EN defined:
//  - A 32-bit counter runs in ARM+POLL and clears on job accept.
//  - Reaching TIMEOUT_CYC: write 8'h00 to A_CTRL (clear go), skip FINAL, enter RESP with res_timeout=1, res_found=0.
//  FRAC_PI_MASTER_TIMEOUT_EN undefined:
//  - No counter; POLL waits indefinitely; res_timeout tied 0.
// TESTING
//  T1 Job cx=32'h12345678, cy=32'h9ABCDEF0, iter=16'h0100:
//     - writes addr1..10 = 78,56,34,12,F0,DE,BC,9A,00,01 in cycles 1..10
//     - addr0=01 in cycle 11
//  T2 Slave model busy=1 for 40 cycles, found=1:
//     - reads spaced POLL_GAP+1 apart; FINAL read
//     - res_valid=1, res_found=1, res_timeout=0
//  T3 Busy never rises, found=0:
//     - exactly ARM_WAIT reads, then FINAL
//     - res_found=0, res_timeout=0
//  T4 res_ready low 5 cycles:
//     - res_valid and res_found held, job_ready=0, job_valid ignored
//     - job accepted only after handshake
//  T5 TIMEOUT_EN, TIMEOUT_CYC=64, busy stuck high:
//     - write addr0=00
//     - res_valid with res_timeout=1, res_found=0
//  T6 rst_n pulsed low during WR byte 5:
//     - all outputs 0 immediately
//     - after release job_ready=1 next edge, no further writes until new job

Source files
------------

// File: rtl/frac_pi_master.sv
// ---------------------------------------------------------------------------
// frac_pi_master
// Bus initiator that loads one fractal point job (cx, cy, max_iter) into the
// fractal unit register block, sets the go bit, polls the status register
// until the unit goes idle, and then returns the found flag.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   job_valid/job_ready             job request handshake (ready only in IDLE)
//   job_cx, job_cy, job_max_iter    job fields, latched on accept
//   res_valid/res_ready             result handshake, result held until taken
//   res_found, res_timeout          result flags
//   blk_sel, addr, wr_en, rd_en,
//   wr_data                         registered register-bus outputs
//   rd_data                         read data, sampled in the rd_en cycle
//
// Optional feature: define FRAC_PI_MASTER_TIMEOUT_EN to add a busy-time
// watchdog (TIMEOUT_CYC cycles in ARM+POLL), which clears go and returns a
// result with res_timeout=1. Without it the master waits indefinitely.
// ---------------------------------------------------------------------------
module frac_pi_master #(
    parameter logic [3:0]  A_CTRL   = 4'h0,
    parameter logic [3:0]  A_CX0    = 4'h1,
    parameter logic [3:0]  A_CY0    = 4'h5,
    parameter logic [3:0]  A_ITER0  = 4'h9,
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned ARM_WAIT = 16
`ifdef FRAC_PI_MASTER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 65536
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_cx,
    input  logic [31:0] job_cy,
    input  logic [15:0] job_max_iter,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_found,
    output logic        res_timeout,
    output logic        blk_sel,
    output logic [3:0]  addr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [7:0]  wr_data,
    input  logic [7:0]  rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_GO, S_ARM, S_POLL, S_FINAL, S_RESP, S_ABORT
    } state_t;

    localparam logic [15:0] ARM_LAST = 16'(ARM_WAIT);
    localparam logic [7:0]  GAP_M1   = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    // Register address of job byte idx (0..3 cx, 4..7 cy, 8..9 max_iter)
    function automatic logic [3:0] job_addr(input logic [3:0] idx);
        logic [3:0] a;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3: a = A_CX0 + {2'b00, idx[1:0]};
            4'd4, 4'd5, 4'd6, 4'd7: a = A_CY0 + {2'b00, idx[1:0]};
            4'd8:                   a = A_ITER0;
            4'd9:                   a = A_ITER0 + 4'd1;
            default:                a = A_CTRL;
        endcase
        return a;
    endfunction

    // Data byte of job byte idx, low byte first within each field
    function automatic logic [7:0] job_byte(input logic [3:0] idx, input logic [31:0] cx,
                                            input logic [31:0] cy, input logic [15:0] it);
        logic [7:0] b;
        case (idx)
            4'd0:    b = cx[7:0];
            4'd1:    b = cx[15:8];
            4'd2:    b = cx[23:16];
            4'd3:    b = cx[31:24];
            4'd4:    b = cy[7:0];
            4'd5:    b = cy[15:8];
            4'd6:    b = cy[23:16];
            4'd7:    b = cy[31:24];
            4'd8:    b = it[7:0];
            4'd9:    b = it[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] arm_q, arm_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] cx_q, cx_d, cy_q, cy_d;
    logic [15:0] iter_q, iter_d;
    logic        job_ready_q, job_ready_d;
    logic        res_valid_q, res_valid_d;
    logic        res_found_q, res_found_d;
    logic        res_timeout_q, res_timeout_d;
    logic        blk_sel_q, blk_sel_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    // Access requested for the next cycle; turned into bus flops below
    logic        do_rd_s, do_wr_s;
    logic [3:0]  wa_s;
    logic [7:0]  wd_s;
    logic        accept_s;
    logic        timeout_hit_s;
    logic        unused_rd_s;

    assign accept_s    = (state_q == S_IDLE) && job_valid && job_ready_q;
    assign unused_rd_s = ^rd_data[7:2];

`ifdef FRAC_PI_MASTER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] timer_q, timer_d;

    // Busy-time watchdog: cleared on accept, counts while waiting on the unit
    always_comb begin
        timer_d = timer_q;
        if (accept_s) begin
            timer_d = 32'd0;
        end else if ((state_q == S_ARM) || (state_q == S_POLL)) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout_hit_s = ((state_q == S_ARM) || (state_q == S_POLL)) && (timer_q == TO_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-access logic of the job sequencer
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        arm_d         = arm_q;
        gap_d         = gap_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        iter_d        = iter_q;
        res_valid_d   = res_valid_q;
        res_found_d   = res_found_q;
        res_timeout_d = res_timeout_q;
        do_rd_s       = 1'b0;
        do_wr_s       = 1'b0;
        wa_s          = A_CTRL;
        wd_s          = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cx_d          = job_cx;
                    cy_d          = job_cy;
                    iter_d        = job_max_iter;
                    idx_d         = 4'd0;
                    res_found_d   = 1'b0;
                    res_timeout_d = 1'b0;
                    do_wr_s       = 1'b1;
                    wa_s          = job_addr(4'd0);
                    wd_s          = job_byte(4'd0, job_cx, job_cy, job_max_iter);
                    state_d       = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                do_wr_s = 1'b1;
                if (idx_q == 4'd9) begin
                    wa_s    = A_CTRL;
                    wd_s    = 8'h01;
                    state_d = S_GO;
                end else begin
                    idx_d = idx_q + 4'd1;
                    wa_s  = job_addr(idx_q + 4'd1);
                    wd_s  = job_byte(idx_q + 4'd1, cx_q, cy_q, iter_q);
                end
            end
            S_GO: begin
                do_rd_s = 1'b1;
                arm_d   = 16'd1;
                state_d = S_ARM;
            end
            S_ARM, S_POLL: begin
                if (timeout_hit_s) begin
                    do_wr_s = 1'b1;
                    wd_s    = 8'h00;
                    state_d = S_ABORT;
                end else if (rd_en_q && !rd_data[0] &&
                             ((state_q == S_POLL) || (arm_q == ARM_LAST))) begin
                    // Idle seen (or busy never rose): one confirming read
                    do_rd_s = 1'b1;
                    state_d = S_FINAL;
                end else if (state_q == S_ARM && !rd_data[0]) begin
                    do_rd_s = 1'b1;
                    arm_d   = arm_q + 16'd1;
                end else if (rd_en_q) begin
                    // Busy confirmed: start a poll gap (or read again at once)
                    state_d = S_POLL;
                    if (POLL_GAP == 0) begin
                        do_rd_s = 1'b1;
                    end else begin
                        gap_d = GAP_M1;
                    end
                end else if (gap_q == 8'd0) begin
                    do_rd_s = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_FINAL: begin
                res_found_d   = rd_data[1];
                res_timeout_d = 1'b0;
                res_valid_d   = 1'b1;
                state_d       = S_RESP;
            end
            S_ABORT: begin
                res_found_d   = 1'b0;
                res_timeout_d = 1'b1;
                res_valid_d   = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        job_ready_d = (state_d == S_IDLE);
        blk_sel_d   = do_rd_s | do_wr_s;
        rd_en_d     = do_rd_s;
        wr_en_d     = do_wr_s;
        addr_d      = (do_rd_s | do_wr_s) ? wa_s : 4'h0;
        wr_data_d   = do_wr_s ? wd_s : 8'h00;
    end

    // Sequencer state, latched job and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 4'd0;
            arm_q         <= 16'd0;
            gap_q         <= 8'd0;
            cx_q          <= 32'd0;
            cy_q          <= 32'd0;
            iter_q        <= 16'd0;
            job_ready_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_found_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            blk_sel_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            addr_q        <= 4'h0;
            wr_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            arm_q         <= arm_d;
            gap_q         <= gap_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            iter_q        <= iter_d;
            job_ready_q   <= job_ready_d;
            res_valid_q   <= res_valid_d;
            res_found_q   <= res_found_d;
            res_timeout_q <= res_timeout_d;
            blk_sel_q     <= blk_sel_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign job_ready   = job_ready_q;
    assign res_valid   = res_valid_q;
    assign res_found   = res_found_q;
    assign res_timeout = res_timeout_q;
    assign blk_sel     = blk_sel_q;
    assign addr        = addr_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_frac_pi_master.sv
// ---------------------------------------------------------------------------
// tb_frac_pi_master
// Directed bench for frac_pi_master with a small behavioural model of the
// fractal unit status register (busy for a set number of cycles after go,
// fixed found bit). Expected cycle numbers count from the accept cycle
// (cycle 0); bus activity is logged on the falling edge.
// ---------------------------------------------------------------------------
module tb_frac_pi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid, job_ready;
    logic [31:0] job_cx, job_cy;
    logic [15:0] job_max_iter;
    logic        res_valid, res_ready, res_found, res_timeout;
    logic        blk_sel, wr_en, rd_en;
    logic [3:0]  addr;
    logic [7:0]  wr_data, rd_data;

    always #5 clk = ~clk;

`ifdef FRAC_PI_MASTER_TIMEOUT_EN
    frac_pi_master #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_cx(job_cx), .job_cy(job_cy), .job_max_iter(job_max_iter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_timeout(res_timeout),
        .blk_sel(blk_sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data)
    );
`else
    frac_pi_master dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_cx(job_cx), .job_cy(job_cy), .job_max_iter(job_max_iter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_timeout(res_timeout),
        .blk_sel(blk_sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data)
    );
`endif

    // Status register model; busy_len = -1 means busy never clears
    int   busy_len  = 0;
    int   busy_left = 0;
    logic found_m   = 1'b0;
    int   cyc       = 0;

    assign rd_data = (rd_en && addr == 4'h0) ? {6'b000000, found_m, (busy_left != 0)} : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en && addr == 4'h0) busy_left <= wr_data[0] ? busy_len : 0;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end

    // Bus log and bus-rule monitor
    int         w_cyc[$];
    logic [3:0] w_addr[$];
    logic [7:0] w_dat[$];
    int         r_cyc[$];
    int         viol = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(addr);
            w_dat.push_back(wr_data);
        end
        if (rd_en) r_cyc.push_back(cyc);
        if (wr_en && rd_en) viol = viol + 1;
        if ((wr_en || rd_en) != blk_sel) viol = viol + 1;
        if (!wr_en && !rd_en && (addr != 4'h0 || wr_data != 8'h00)) viol = viol + 1;
        if (rd_en && addr != 4'h0) viol = viol + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int acc    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a job and wait (bounded) until it is taken; acc = cycle 1 stamp
    task automatic start_job(input logic [31:0] cx, input logic [31:0] cy, input logic [15:0] it);
        bit ok;
        ok = 1'b0;
        job_cx = cx; job_cy = cy; job_max_iter = it; job_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (job_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_val("job_accept_wait", 64'(ok), 64'd1);
        acc = cyc + 1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // Wait (bounded) for res_valid; rel is the cycle number relative to accept
    task automatic wait_res(output int rel);
        bit ok;
        ok  = 1'b0;
        rel = -1;
        for (int i = 0; i < 400; i++) begin
            if (res_valid) begin ok = 1'b1; rel = cyc - acc + 1; break; end
            @(negedge clk);
        end
        check_val("res_valid_wait", 64'(ok), 64'd1);
    endtask

    function automatic logic [27:0] wpack(input int i);
        return {16'(w_cyc[i] - acc + 1), w_addr[i], w_dat[i]};
    endfunction

    logic [3:0] t1_addr[11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0};
    logic [7:0] t1_data[11] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A,
                                8'h00, 8'h01, 8'h01};

    int rel, wb, rb, wn;

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b1;
        job_cx = 32'd0; job_cy = 32'd0; job_max_iter = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("reset_outputs", 64'({job_ready, res_valid, res_found, res_timeout, blk_sel,
                                        addr, wr_en, rd_en, wr_data}), 64'd0);
        rst_n = 1'b1;
        #1 check_val("ready_before_edge", 64'(job_ready), 64'd0);
        @(negedge clk);
        check_val("ready_after_release", 64'(job_ready), 64'd1);

        // T1 + T2: write sequence, then 40 busy cycles with found=1
        busy_len = 40; found_m = 1'b1;
        wb = w_cyc.size(); rb = r_cyc.size();
        start_job(32'h12345678, 32'h9ABCDEF0, 16'h0100);
        wait_res(rel);
        check_val("t2_res_cycle", 64'(rel), 64'd54);
        check_val("t2_found", 64'(res_found), 64'd1);
        check_val("t2_timeout", 64'(res_timeout), 64'd0);
        check_val("t1_wr_count", 64'(w_cyc.size() - wb), 64'd11);
        if (w_cyc.size() - wb == 11) begin
            for (int i = 0; i < 11; i++)
                check_val($sformatf("t1_wr%0d", i), 64'(wpack(wb + i)),
                          64'({16'(i + 1), t1_addr[i], t1_data[i]}));
        end
        check_val("t2_rd_count", 64'(r_cyc.size() - rb), 64'd10);
        if (r_cyc.size() - rb == 10) begin
            check_val("t2_first_rd", 64'(r_cyc[rb] - acc + 1), 64'd12);
            check_val("t2_poll_gap", 64'(r_cyc[rb + 8] - r_cyc[rb + 7]), 64'd5);
            check_val("t2_last_poll", 64'(r_cyc[rb + 8] - acc + 1), 64'd52);
            check_val("t2_final_rd", 64'(r_cyc[rb + 9] - acc + 1), 64'd53);
        end
        @(negedge clk);
        check_val("t2_after_hs", 64'({res_valid, job_ready}), 64'b01);

        // T3: busy never rises, found=0
        busy_len = 0; found_m = 1'b0;
        rb = r_cyc.size();
        start_job(32'h00000001, 32'h00000002, 16'h0003);
        wait_res(rel);
        check_val("t3_res_cycle", 64'(rel), 64'd29);
        check_val("t3_found", 64'(res_found), 64'd0);
        check_val("t3_timeout", 64'(res_timeout), 64'd0);
        check_val("t3_rd_count", 64'(r_cyc.size() - rb), 64'd17);
        if (r_cyc.size() - rb == 17) begin
            check_val("t3_last_arm_rd", 64'(r_cyc[rb + 15] - acc + 1), 64'd27);
            check_val("t3_final_rd", 64'(r_cyc[rb + 16] - acc + 1), 64'd28);
        end
        @(negedge clk);

        // T4: consumer stalls 5 cycles while a new job is offered
        busy_len = 0; found_m = 1'b1; res_ready = 1'b0;
        start_job(32'hA5A5A5A5, 32'h5A5A5A5A, 16'h0010);
        wait_res(rel);
        job_cx = 32'h00000011; job_cy = 32'h00000022; job_max_iter = 16'h0033;
        job_valid = 1'b1;
        wn = w_cyc.size();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t4_hold%0d", i), 64'({res_valid, res_found, job_ready}), 64'b110);
            @(negedge clk);
        end
        check_val("t4_no_writes", 64'(w_cyc.size() - wn), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        check_val("t4_after_hs", 64'({res_valid, job_ready}), 64'b01);
        acc = cyc + 1;
        @(negedge clk);
        job_valid = 1'b0;
        check_val("t4_next_wr", 64'({wr_en, addr, wr_data}), 64'({1'b1, 4'h1, 8'h11}));
        wait_res(rel);
        @(negedge clk);

`ifdef FRAC_PI_MASTER_TIMEOUT_EN
        // T5: busy stuck high, watchdog aborts
        busy_len = -1; found_m = 1'b1;
        start_job(32'h0000_00FF, 32'h0000_00EE, 16'hFFFF);
        wait_res(rel);
        check_val("t5_res_cycle", 64'(rel), 64'd77);
        check_val("t5_flags", 64'({res_timeout, res_found}), 64'b10);
        check_val("t5_clear_go", 64'(wpack(w_cyc.size() - 1)), 64'({16'd76, 4'h0, 8'h00}));
        @(negedge clk);
`endif

        // T6: reset during the fifth job byte write
        busy_len = 0; found_m = 1'b0;
        start_job(32'hCAFEF00D, 32'h0BADBEEF, 16'h1234);
        repeat (4) @(negedge clk);
        check_val("t6_mid_write", 64'({wr_en, addr}), 64'({1'b1, 4'h5}));
        rst_n = 1'b0;
        #1 check_val("t6_reset_outputs", 64'({job_ready, res_valid, res_found, res_timeout,
                                              blk_sel, addr, wr_en, rd_en, wr_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wn = w_cyc.size();
        @(negedge clk);
        check_val("t6_ready_after", 64'(job_ready), 64'd1);
        repeat (20) @(negedge clk);
        check_val("t6_no_writes", 64'(w_cyc.size() - wn), 64'd0);
        check_val("t6_idle_res", 64'(res_valid), 64'd0);

        check_val("bus_rules", 64'(viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
